cfg_chain_loader: RTL and testbench



---
 rtl/cfg_chain_loader.sv | 112 +++++++++++
 tb/tb_cfg_chain_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: packs a serial configuration bitstream into CFG_WIDTH-bit
// words and strobes each word into one of NUM_TARGETS configurable blocks.
module cfg_chain_loader #(
  parameter int CFG_WIDTH   = 4,
  parameter int NUM_TARGETS = 4
) (
  input  logic                   cclk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  output logic [CFG_WIDTH-1:0]   cfg_data,
  output logic [NUM_TARGETS-1:0] cfg_en,
  output logic                   busy,
  output logic                   done
);

  localparam int BW = $clog2(CFG_WIDTH);
  localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(CFG_WIDTH - 1);
  localparam logic [TW-1:0] LAST_TGT = TW'(NUM_TARGETS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [BW-1:0]        bit_cnt;
  logic [TW-1:0]        tgt_idx;
  logic [CFG_WIDTH-1:0] shreg;
  logic [CFG_WIDTH-1:0] last_data;
  logic                 accept;

  assign accept = bit_valid && (state == SHIFT);

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs decode from state and registers only, so reset clears them at once
  always_comb begin
    state_next = state;
    bit_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cfg_en     = '0;
    cfg_data   = last_data;
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        if (accept && (bit_cnt == LAST_BIT)) state_next = COMMIT;
      end
      COMMIT: begin
        busy       = 1'b1;
        cfg_en     = NUM_TARGETS'(1) << tgt_idx;
        cfg_data   = shreg;
        state_next = (tgt_idx == LAST_TGT) ? DONE : SHIFT;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = SHIFT;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      tgt_idx   <= '0;
      shreg     <= '0;
      last_data <= '0;
    end else if (abort) begin
      bit_cnt   <= '0;
      tgt_idx   <= '0;
      shreg     <= '0;
      last_data <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bit_cnt <= '0;
            tgt_idx <= '0;
          end
        end
        SHIFT: begin
          if (accept) begin
            shreg   <= {shreg[CFG_WIDTH-2:0], bit_in};
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
          end
        end
        COMMIT: begin
          // Remember the committed word so cfg_data holds it between strobes
          last_data <= shreg;
          if (tgt_idx != LAST_TGT) tgt_idx <= tgt_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: randomized loads with a commit scoreboard and a
// timeline model derived from the accept/commit rules of the loader.
module tb_cfg_chain_loader;

  localparam int CW = 4;
  localparam int NT = 4;

  logic          cclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic [CW-1:0] cfg_data;
  logic [NT-1:0] cfg_en;
  logic          busy;
  logic          done;

  logic          s_start = 1'b0;
  logic          s_abort = 1'b0;
  logic          s_bit_in = 1'b0;
  logic          s_bit_valid = 1'b0;
  logic          s_bit_ready;
  logic [1:0]    s_cfg_data;
  logic [0:0]    s_cfg_en;
  logic          s_busy;
  logic          s_done;

  typedef struct {
    int            c;
    logic [NT-1:0] en;
    logic [CW-1:0] data;
  } commit_t;

  commit_t       exp_q[$];
  logic [CW-1:0] hold_exp = '0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  cfg_chain_loader #(.CFG_WIDTH(CW), .NUM_TARGETS(NT)) dut (
    .cclk(cclk), .rst_n(rst_n), .start(start), .abort(abort),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .cfg_data(cfg_data), .cfg_en(cfg_en), .busy(busy), .done(done)
  );

  cfg_chain_loader #(.CFG_WIDTH(2), .NUM_TARGETS(1)) dut_small (
    .cclk(cclk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .bit_in(s_bit_in), .bit_valid(s_bit_valid), .bit_ready(s_bit_ready),
    .cfg_data(s_cfg_data), .cfg_en(s_cfg_en), .busy(s_busy), .done(s_done)
  );

  always #5 cclk = ~cclk;

  always @(posedge cclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  // Every strobe must match the next expected commit; between strobes the bus holds
  always @(negedge cclk) begin
    commit_t e;
    if (rst_n) begin
      if (cfg_en != '0) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_strobe", 32'(cfg_en), 32'(0));
        end else begin
          e = exp_q.pop_front();
          checkOutput("commit_cycle", 32'(cyc), 32'(e.c));
          checkOutput("commit_en", 32'(cfg_en), 32'(e.en));
          checkOutput("commit_data", 32'(cfg_data), 32'(e.data));
          hold_exp = e.data;
        end
      end else begin
        checkOutput("hold_data", 32'(cfg_data), 32'(hold_exp));
      end
    end
  end

  task automatic doAbort();
    abort     = 1'b1;
    bit_valid = 1'($urandom_range(0, 1));
    bit_in    = 1'($urandom_range(0, 1));
    tick();
    abort     = 1'b0;
    bit_valid = 1'b0;
    hold_exp  = '0;
    checkOutput("abort_idle", 32'({bit_ready, busy, done, cfg_en}), 32'(0));
  endtask

  task automatic startAbort(input string name);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start    = 1'b0;
    abort    = 1'b0;
    hold_exp = '0;
    checkOutput(name, 32'({bit_ready, busy, done}), 32'(0));
    tick();
    checkOutput({name, "_stays"}, 32'({bit_ready, busy, done}), 32'(0));
  endtask

  // Runs one load; a word completes after CW accepted bits and commits in the
  // following cycle, bits offered in a commit cycle are never consumed.
  task automatic applyStimulus(input logic [CW-1:0] words [NT], input int gap_word,
                               input int gap_len, input bit rand_gaps, input int abort_word,
                               input int abort_bit, input bit glitch_start,
                               input int reset_word);
    logic [NT-1:0] onehot;
    start     = 1'b1;
    bit_valid = 1'($urandom_range(0, 1));
    bit_in    = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    for (int w = 0; w < NT; w++) begin
      for (int b = 0; b < CW; b++) begin
        int gaps;
        gaps = 0;
        if (w == gap_word && b == CW / 2) gaps = gap_len;
        else if (rand_gaps && $urandom_range(0, 3) == 0) gaps = int'($urandom_range(1, 3));
        if (w == abort_word && b == abort_bit) begin
          doAbort();
          return;
        end
        for (int g = 0; g < gaps; g++) begin
          bit_valid = 1'b0;
          bit_in    = 1'($urandom_range(0, 1));
          checkOutput("gap_ready", 32'({bit_ready, busy, done}), 32'(3'b110));
          tick();
        end
        bit_valid = 1'b1;
        bit_in    = words[w][CW-1-b];
        start     = glitch_start && (w == 1) && (b == 1);
        checkOutput("shift_ready", 32'({bit_ready, busy, done}), 32'(3'b110));
        tick();
        start = 1'b0;
      end
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      if (w == reset_word) begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_commit",
                    32'({bit_ready, busy, done, cfg_en, cfg_data}), 32'(0));
        hold_exp  = '0;
        bit_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        return;
      end
      onehot    = '0;
      onehot[w] = 1'b1;
      exp_q.push_back('{c: cyc, en: onehot, data: words[w]});
      checkOutput("commit_flags", 32'({bit_ready, busy, done}), 32'(3'b010));
      if (w == abort_word && abort_bit == CW) begin
        doAbort();
        return;
      end
      tick();
    end
    bit_valid = 1'b0;
    checkOutput("done_flags", 32'({bit_ready, busy, done, cfg_en}), 32'({3'b001, 4'b0000}));
    tick();
    checkOutput("done_held", 32'(done), 32'(1));
  endtask

  task automatic randomWords(output logic [CW-1:0] words [NT]);
    for (int i = 0; i < NT; i++) words[i] = CW'($urandom);
  endtask

  task automatic checkScoreboard(input string name);
    checkOutput(name, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  initial begin
    logic [CW-1:0] basic [NT];
    logic [CW-1:0] rw [NT];
    basic = '{4'b1011, 4'b0110, 4'b0001, 4'b1111};

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n     = 1'b1;
    bit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checkOutput("idle_outputs", 32'({bit_ready, busy, done, cfg_en, cfg_data}), 32'(0));
      tick();
    end
    bit_valid = 1'b0;

    s_start = 1'b1;
    tick();
    s_start     = 1'b0;
    s_bit_valid = 1'b1;
    s_bit_in    = 1'b1;
    checkOutput("small_ready", 32'({s_bit_ready, s_cfg_en}), 32'(2'b10));
    tick();
    s_bit_in = 1'b0;
    checkOutput("small_second_bit", 32'({s_bit_ready, s_cfg_en}), 32'(2'b10));
    tick();
    s_bit_in = 1'b1;
    checkOutput("small_commit", 32'({s_cfg_en, s_cfg_data, s_busy, s_done}), 32'(5'b11010));
    tick();
    s_bit_valid = 1'b0;
    checkOutput("small_done", 32'({s_cfg_en, s_cfg_data, s_busy, s_done}), 32'(5'b01001));

    $display("[TB] basic load");
    applyStimulus(basic, -1, 0, 1'b0, -1, -1, 1'b0, -1);
    checkScoreboard("basic_all_commits");

    $display("[TB] backpressure gap in word 2");
    applyStimulus(basic, 1, 3, 1'b0, -1, -1, 1'b0, -1);
    checkScoreboard("gap_all_commits");

    $display("[TB] abort after 2 bits of word 3");
    applyStimulus(basic, -1, 0, 1'b0, 2, 2, 1'b0, -1);
    checkScoreboard("abort_no_third_strobe");
    randomWords(rw);
    applyStimulus(rw, -1, 0, 1'b1, -1, -1, 1'b1, -1);
    checkScoreboard("reload_after_abort");

    $display("[TB] abort during commit");
    randomWords(rw);
    applyStimulus(rw, -1, 0, 1'b0, 0, CW, 1'b0, -1);
    checkScoreboard("abort_commit_strobe");

    startAbort("start_abort_idle");
    randomWords(rw);
    applyStimulus(rw, -1, 0, 1'b1, -1, -1, 1'b0, -1);
    checkScoreboard("load_before_done_abort");
    startAbort("start_abort_done");

    $display("[TB] reset during commit of target 1");
    randomWords(rw);
    applyStimulus(rw, -1, 0, 1'b0, -1, -1, 1'b0, 1);
    checkScoreboard("reset_drops_strobe");
    checkOutput("post_reset_idle", 32'({bit_ready, busy, done, cfg_en, cfg_data}), 32'(0));

    for (int k = 0; k < 6; k++) begin
      randomWords(rw);
      applyStimulus(rw, -1, 0, 1'b1, -1, -1, k[0], -1);
      checkScoreboard("random_load");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
